// File: rtl/pwm8_pkg.sv
// ---------------------------------------------------------------------------
// pwm8_pkg
// Shared definitions for the PWM8 register-bus front end:
//   - byte offsets of every mapped core register
//   - register-select enum produced by the address decoder
//   - response payload struct carried by the response queue
//   - decode and byte-mask expansion helpers
// ---------------------------------------------------------------------------
package pwm8_pkg;

   localparam logic [5:0] PWM8_OFS_CFG     = 6'h00;
   localparam logic [5:0] PWM8_OFS_COUNTLO = 6'h08;
   localparam logic [5:0] PWM8_OFS_COUNTHI = 6'h0C;
   localparam logic [5:0] PWM8_OFS_S       = 6'h10;
   localparam logic [5:0] PWM8_OFS_FEED    = 6'h18;
   localparam logic [5:0] PWM8_OFS_KEY     = 6'h1C;
   localparam logic [5:0] PWM8_OFS_CMP0    = 6'h20;
   localparam logic [5:0] PWM8_OFS_CMP1    = 6'h24;
   localparam logic [5:0] PWM8_OFS_CMP2    = 6'h28;
   localparam logic [5:0] PWM8_OFS_CMP3    = 6'h2C;

   localparam int PWM8_NUM_REGS = 10;

   // Enum values double as the bit index into the write-strobe vector.
   typedef enum logic [3:0] {
      SEL_CFG     = 4'd0,
      SEL_COUNTLO = 4'd1,
      SEL_COUNTHI = 4'd2,
      SEL_S       = 4'd3,
      SEL_CMP0    = 4'd4,
      SEL_CMP1    = 4'd5,
      SEL_CMP2    = 4'd6,
      SEL_CMP3    = 4'd7,
      SEL_FEED    = 4'd8,
      SEL_KEY     = 4'd9,
      SEL_NONE    = 4'd10
   } reg_sel_e;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   // Only the word offset (address bits [5:2]) takes part in the decode.
   function automatic reg_sel_e pwm8_decode(input logic [3:0] word);
      logic [5:0] ofs;
      reg_sel_e   sel;
      ofs = {word, 2'b00};
      case (ofs)
         PWM8_OFS_CFG:     sel = SEL_CFG;
         PWM8_OFS_COUNTLO: sel = SEL_COUNTLO;
         PWM8_OFS_COUNTHI: sel = SEL_COUNTHI;
         PWM8_OFS_S:       sel = SEL_S;
         PWM8_OFS_FEED:    sel = SEL_FEED;
         PWM8_OFS_KEY:     sel = SEL_KEY;
         PWM8_OFS_CMP0:    sel = SEL_CMP0;
         PWM8_OFS_CMP1:    sel = SEL_CMP1;
         PWM8_OFS_CMP2:    sel = SEL_CMP2;
         PWM8_OFS_CMP3:    sel = SEL_CMP3;
         default:          sel = SEL_NONE;
      endcase
      return sel;
   endfunction

   function automatic logic [31:0] pwm8_expand_mask(input logic [3:0] m);
      return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
   endfunction

endpackage

// File: rtl/pwm8_icb_regif_if.sv
// ---------------------------------------------------------------------------
// pwm8_icb_regif_if
// ICB command/response channel between the peripheral fabric (master) and
// the PWM8 register front end (slave).
//   cmd: i_icb_cmd_valid / o_icb_cmd_ready, addr, read, wdata, wmask
//   rsp: o_icb_rsp_valid / i_icb_rsp_ready, rdata, err
// Signal names carry the direction as seen from the slave.
// ---------------------------------------------------------------------------
interface pwm8_icb_regif_if #(
   parameter int ADDR_W = 12
);
   logic              i_icb_cmd_valid;
   logic              o_icb_cmd_ready;
   logic [ADDR_W-1:0] i_icb_cmd_addr;
   logic              i_icb_cmd_read;
   logic [31:0]       i_icb_cmd_wdata;
   logic [3:0]        i_icb_cmd_wmask;
   logic              o_icb_rsp_valid;
   logic              i_icb_rsp_ready;
   logic [31:0]       o_icb_rsp_rdata;
   logic              o_icb_rsp_err;

   modport master (
      output i_icb_cmd_valid, i_icb_cmd_addr, i_icb_cmd_read,
             i_icb_cmd_wdata, i_icb_cmd_wmask, i_icb_rsp_ready,
      input  o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_rdata, o_icb_rsp_err
   );

   modport slave (
      input  i_icb_cmd_valid, i_icb_cmd_addr, i_icb_cmd_read,
             i_icb_cmd_wdata, i_icb_cmd_wmask, i_icb_rsp_ready,
      output o_icb_cmd_ready, o_icb_rsp_valid, o_icb_rsp_rdata, o_icb_rsp_err
   );
endinterface

// File: rtl/pwm8_regif_rsp_fifo.sv
// ---------------------------------------------------------------------------
// pwm8_regif_rsp_fifo
// Response queue of depth 1 or 2 with wrapping read/write pointers.
//   clock, reset   : clock, asynchronous active-high reset
//   i_push         : load i_push_data (ignored when full unless popping)
//   i_pop          : discard the head entry (ignored when empty)
//   o_head         : head entry, stable while not popped
//   o_full/o_empty : registered status flags
// ---------------------------------------------------------------------------
module pwm8_regif_rsp_fifo
   import pwm8_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic i_push,
   input  rsp_t i_push_data,
   input  logic i_pop,
   output rsp_t o_head,
   output logic o_full,
   output logic o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   rsp_t             r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_full;
   logic             r_empty;

   logic             w_push_ok;
   logic             w_pop_ok;
   logic [CNT_W-1:0] w_count_nxt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A push into a full queue is legal only together with a pop: the head
   // slot is freed on the same edge.
   assign w_pop_ok  = i_pop & ~r_empty;
   assign w_push_ok = i_push & (~r_full | w_pop_ok);

   always_comb begin
      w_count_nxt = r_count;
      case ({w_push_ok, w_pop_ok})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
            r_wr_ptr        <= ptr_inc(r_wr_ptr);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CNT_W'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/pwm8_icb_regif.sv
// ---------------------------------------------------------------------------
// pwm8_icb_regif
// ICB register front end for the 8-bit PWM core. Decodes the word offset of
// each accepted command, returns read data sampled from the core's _read
// buses in the accept cycle, and issues a one-cycle write strobe with the
// byte-merged value on the cycle after a write is accepted.
//
// Ports
//   clock, reset          : clock, asynchronous active-high reset
//   icb (slave)           : ICB command / response channel
//   io_regs_<r>_write_valid / _write_bits : write strobe and merged value
//   io_regs_<r>_read      : current core register value
//
// Build option
//   PWM8_REGIF_RSP_FIFO_EN : 2-entry response FIFO with registered cmd_ready.
//   Undefined              : single response register; cmd_ready is
//                            ~rsp_valid | rsp_ready (combinational).
// ---------------------------------------------------------------------------
module pwm8_icb_regif
   import pwm8_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clock,
   input  logic              reset,
   pwm8_icb_regif_if.slave   icb,

   output logic              io_regs_cfg_write_valid,
   output logic [31:0]       io_regs_cfg_write_bits,
   input  logic [31:0]       io_regs_cfg_read,
   output logic              io_regs_countLo_write_valid,
   output logic [31:0]       io_regs_countLo_write_bits,
   input  logic [31:0]       io_regs_countLo_read,
   output logic              io_regs_countHi_write_valid,
   output logic [31:0]       io_regs_countHi_write_bits,
   input  logic [31:0]       io_regs_countHi_read,
   output logic              io_regs_s_write_valid,
   output logic [7:0]        io_regs_s_write_bits,
   input  logic [7:0]        io_regs_s_read,
   output logic              io_regs_cmp_0_write_valid,
   output logic [7:0]        io_regs_cmp_0_write_bits,
   input  logic [7:0]        io_regs_cmp_0_read,
   output logic              io_regs_cmp_1_write_valid,
   output logic [7:0]        io_regs_cmp_1_write_bits,
   input  logic [7:0]        io_regs_cmp_1_read,
   output logic              io_regs_cmp_2_write_valid,
   output logic [7:0]        io_regs_cmp_2_write_bits,
   input  logic [7:0]        io_regs_cmp_2_read,
   output logic              io_regs_cmp_3_write_valid,
   output logic [7:0]        io_regs_cmp_3_write_bits,
   input  logic [7:0]        io_regs_cmp_3_read,
   output logic              io_regs_feed_write_valid,
   output logic [31:0]       io_regs_feed_write_bits,
   input  logic [31:0]       io_regs_feed_read,
   output logic              io_regs_key_write_valid,
   output logic [31:0]       io_regs_key_write_bits,
   input  logic [31:0]       io_regs_key_read
);

`ifdef PWM8_REGIF_RSP_FIFO_EN
   localparam int RSP_DEPTH = 2;
`else
   localparam int RSP_DEPTH = 1;
`endif

   reg_sel_e                 w_sel;
   logic [31:0]              w_rd_val;
   logic [31:0]              w_bitmask;
   logic [31:0]              w_merged;
   logic                     w_accept;
   logic                     w_wr_hit;
   logic                     w_cmd_ready;
   rsp_t                     w_rsp_push;
   rsp_t                     w_rsp_head;
   logic                     w_fifo_full;
   logic                     w_fifo_empty;
   logic                     w_rsp_pop;
   logic                     w_unused_addr;

   logic [PWM8_NUM_REGS-1:0] r_wv;
   logic [31:0]              r_wbits;

   assign w_sel         = pwm8_decode(icb.i_icb_cmd_addr[5:2]);
   assign w_unused_addr = ^{icb.i_icb_cmd_addr[ADDR_W-1:6], icb.i_icb_cmd_addr[1:0]};

   always_comb begin
      w_rd_val = '0;
      case (w_sel)
         SEL_CFG:     w_rd_val = io_regs_cfg_read;
         SEL_COUNTLO: w_rd_val = io_regs_countLo_read;
         SEL_COUNTHI: w_rd_val = io_regs_countHi_read;
         SEL_S:       w_rd_val = {24'h0, io_regs_s_read};
         SEL_CMP0:    w_rd_val = {24'h0, io_regs_cmp_0_read};
         SEL_CMP1:    w_rd_val = {24'h0, io_regs_cmp_1_read};
         SEL_CMP2:    w_rd_val = {24'h0, io_regs_cmp_2_read};
         SEL_CMP3:    w_rd_val = {24'h0, io_regs_cmp_3_read};
         SEL_FEED:    w_rd_val = io_regs_feed_read;
         SEL_KEY:     w_rd_val = io_regs_key_read;
         default:     w_rd_val = '0;
      endcase
   end

   // Unmasked bytes keep the value the core shows in the accept cycle.
   assign w_bitmask = pwm8_expand_mask(icb.i_icb_cmd_wmask);
   assign w_merged  = (icb.i_icb_cmd_wdata & w_bitmask) | (w_rd_val & ~w_bitmask);

   assign w_rsp_pop = ~w_fifo_empty & icb.i_icb_rsp_ready;

`ifdef PWM8_REGIF_RSP_FIFO_EN
   assign w_cmd_ready = ~w_fifo_full;
`else
   // The single slot frees up on the same edge it is drained.
   assign w_cmd_ready = ~w_fifo_full | icb.i_icb_rsp_ready;
`endif

   assign w_accept = icb.i_icb_cmd_valid & w_cmd_ready;
   assign w_wr_hit = w_accept & ~icb.i_icb_cmd_read & (w_sel != SEL_NONE);

   always_comb begin
      w_rsp_push.err   = (w_sel == SEL_NONE);
      w_rsp_push.rdata = (icb.i_icb_cmd_read && (w_sel != SEL_NONE)) ? w_rd_val : 32'h0;
   end

   pwm8_regif_rsp_fifo #(
      .DEPTH       (RSP_DEPTH)
   ) u_rsp_fifo (
      .clock       (clock),
      .reset       (reset),
      .i_push      (w_accept),
      .i_push_data (w_rsp_push),
      .i_pop       (w_rsp_pop),
      .o_head      (w_rsp_head),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty)
   );

   // Strobes self-clear every cycle; the merged value stays until the next
   // write of any register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wv    <= '0;
         r_wbits <= '0;
      end else begin
         r_wv <= '0;
         if (w_wr_hit) begin
            r_wv[w_sel] <= 1'b1;
            r_wbits     <= w_merged;
         end
      end
   end

   assign icb.o_icb_cmd_ready = w_cmd_ready;
   assign icb.o_icb_rsp_valid = ~w_fifo_empty;
   assign icb.o_icb_rsp_rdata = w_rsp_head.rdata;
   assign icb.o_icb_rsp_err   = w_rsp_head.err;

   assign io_regs_cfg_write_valid     = r_wv[SEL_CFG];
   assign io_regs_countLo_write_valid = r_wv[SEL_COUNTLO];
   assign io_regs_countHi_write_valid = r_wv[SEL_COUNTHI];
   assign io_regs_s_write_valid       = r_wv[SEL_S];
   assign io_regs_cmp_0_write_valid   = r_wv[SEL_CMP0];
   assign io_regs_cmp_1_write_valid   = r_wv[SEL_CMP1];
   assign io_regs_cmp_2_write_valid   = r_wv[SEL_CMP2];
   assign io_regs_cmp_3_write_valid   = r_wv[SEL_CMP3];
   assign io_regs_feed_write_valid    = r_wv[SEL_FEED];
   assign io_regs_key_write_valid     = r_wv[SEL_KEY];

   assign io_regs_cfg_write_bits      = r_wbits;
   assign io_regs_countLo_write_bits  = r_wbits;
   assign io_regs_countHi_write_bits  = r_wbits;
   assign io_regs_s_write_bits        = r_wbits[7:0];
   assign io_regs_cmp_0_write_bits    = r_wbits[7:0];
   assign io_regs_cmp_1_write_bits    = r_wbits[7:0];
   assign io_regs_cmp_2_write_bits    = r_wbits[7:0];
   assign io_regs_cmp_3_write_bits    = r_wbits[7:0];
   assign io_regs_feed_write_bits     = r_wbits;
   assign io_regs_key_write_bits      = r_wbits;

endmodule

// File: tb/tb_pwm8_icb_regif.sv
// ---------------------------------------------------------------------------
// tb_pwm8_icb_regif
// Directed bench for pwm8_icb_regif. Expected responses go into a queue when
// a command is accepted and are checked when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_pwm8_icb_regif;
   import pwm8_pkg::*;

   logic clock;
   logic reset;

   pwm8_icb_regif_if #(.ADDR_W(12)) icb ();

   logic        cfg_wv, countLo_wv, countHi_wv, s_wv, cmp0_wv, cmp1_wv, cmp2_wv, cmp3_wv, feed_wv, key_wv;
   logic [31:0] cfg_wb, countLo_wb, countHi_wb, feed_wb, key_wb;
   logic [7:0]  s_wb, cmp0_wb, cmp1_wb, cmp2_wb, cmp3_wb;
   logic [31:0] core_val [10];

   int   n_cmp  = 0;
   int   n_fail = 0;
   rsp_t exp_q [$];

   pwm8_icb_regif #(.ADDR_W(12)) dut (
      .clock                       (clock),
      .reset                       (reset),
      .icb                         (icb),
      .io_regs_cfg_write_valid     (cfg_wv),
      .io_regs_cfg_write_bits      (cfg_wb),
      .io_regs_cfg_read            (core_val[0]),
      .io_regs_countLo_write_valid (countLo_wv),
      .io_regs_countLo_write_bits  (countLo_wb),
      .io_regs_countLo_read        (core_val[1]),
      .io_regs_countHi_write_valid (countHi_wv),
      .io_regs_countHi_write_bits  (countHi_wb),
      .io_regs_countHi_read        (core_val[2]),
      .io_regs_s_write_valid       (s_wv),
      .io_regs_s_write_bits        (s_wb),
      .io_regs_s_read              (core_val[3][7:0]),
      .io_regs_cmp_0_write_valid   (cmp0_wv),
      .io_regs_cmp_0_write_bits    (cmp0_wb),
      .io_regs_cmp_0_read          (core_val[4][7:0]),
      .io_regs_cmp_1_write_valid   (cmp1_wv),
      .io_regs_cmp_1_write_bits    (cmp1_wb),
      .io_regs_cmp_1_read          (core_val[5][7:0]),
      .io_regs_cmp_2_write_valid   (cmp2_wv),
      .io_regs_cmp_2_write_bits    (cmp2_wb),
      .io_regs_cmp_2_read          (core_val[6][7:0]),
      .io_regs_cmp_3_write_valid   (cmp3_wv),
      .io_regs_cmp_3_write_bits    (cmp3_wb),
      .io_regs_cmp_3_read          (core_val[7][7:0]),
      .io_regs_feed_write_valid    (feed_wv),
      .io_regs_feed_write_bits     (feed_wb),
      .io_regs_feed_read           (core_val[8]),
      .io_regs_key_write_valid     (key_wv),
      .io_regs_key_write_bits      (key_wb),
      .io_regs_key_read            (core_val[9])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference register map: index order cfg, countLo, countHi, s, cmp0..3, feed, key.
   function automatic int model_idx(input logic [11:0] a);
      case (a[5:0] & 6'h3C)
         6'h00: return 0;
         6'h08: return 1;
         6'h0C: return 2;
         6'h10: return 3;
         6'h20: return 4;
         6'h24: return 5;
         6'h28: return 6;
         6'h2C: return 7;
         6'h18: return 8;
         6'h1C: return 9;
         default: return -1;
      endcase
   endfunction

   function automatic bit is8(input int idx);
      return (idx >= 3) && (idx <= 7);
   endfunction

   function automatic logic [31:0] core_rd(input int idx);
      if (idx < 0) return 32'h0;
      return is8(idx) ? {24'h0, core_val[idx][7:0]} : core_val[idx];
   endfunction

   function automatic logic [9:0] obs_vec();
      return {key_wv, feed_wv, cmp3_wv, cmp2_wv, cmp1_wv, cmp0_wv, s_wv, countHi_wv, countLo_wv, cfg_wv};
   endfunction

   function automatic logic [31:0] obs_bits(input int idx);
      case (idx)
         0: return cfg_wb;
         1: return countLo_wb;
         2: return countHi_wb;
         3: return {24'h0, s_wb};
         4: return {24'h0, cmp0_wb};
         5: return {24'h0, cmp1_wb};
         6: return {24'h0, cmp2_wb};
         7: return {24'h0, cmp3_wb};
         8: return feed_wb;
         9: return key_wb;
         default: return 32'h0;
      endcase
   endfunction

   function automatic rsp_t exp_rsp(input logic [11:0] a, input logic rd);
      rsp_t r;
      int   idx;
      idx     = model_idx(a);
      r.err   = (idx < 0);
      r.rdata = (rd && idx >= 0) ? core_rd(idx) : 32'h0;
      return r;
   endfunction

   // Response monitor: every presented response must match the queue head;
   // the head is retired on the handshake.
   always @(negedge clock) begin
      if (!reset && icb.o_icb_rsp_valid) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'h1, 32'h0);
         end else begin
            chk(icb.i_icb_rsp_ready ? "rsp_rdata" : "rsp_hold_rdata", icb.o_icb_rsp_rdata, exp_q[0].rdata);
            chk(icb.i_icb_rsp_ready ? "rsp_err" : "rsp_hold_err", {31'h0, icb.o_icb_rsp_err}, {31'h0, exp_q[0].err});
            if (icb.i_icb_rsp_ready) void'(exp_q.pop_front());
         end
      end
   end

   // Issue one command (called just after a rising edge); checks the strobe
   // in the cycle after acceptance and that it is gone one cycle later.
   task automatic issue(input logic [11:0] a, input logic rd, input logic [31:0] wd, input logic [3:0] wm);
      bit          acc;
      int          idx;
      logic [31:0] m;
      logic [31:0] exp_bits;
      logic [9:0]  exp_vec;
      acc = 1'b0;
      idx = model_idx(a);
      icb.i_icb_cmd_valid = 1'b1;
      icb.i_icb_cmd_addr  = a;
      icb.i_icb_cmd_read  = rd;
      icb.i_icb_cmd_wdata = wd;
      icb.i_icb_cmd_wmask = wm;
      for (int c = 0; c < 20 && !acc; c++) begin
         @(negedge clock);
         if (icb.o_icb_cmd_ready) acc = 1'b1;
         @(posedge clock);
         #1;
      end
      icb.i_icb_cmd_valid = 1'b0;
      chk("cmd_accept", {31'h0, acc}, 32'h1);
      if (acc) begin
         exp_q.push_back(exp_rsp(a, rd));
         m        = {{8{wm[3]}}, {8{wm[2]}}, {8{wm[1]}}, {8{wm[0]}}};
         exp_bits = (wd & m) | (core_rd(idx) & ~m);
         if (idx >= 0 && is8(idx)) exp_bits = {24'h0, exp_bits[7:0]};
         exp_vec  = (!rd && idx >= 0) ? (10'b1 << idx) : 10'b0;
         @(negedge clock);
         chk("strobe_T1", {22'h0, obs_vec()}, {22'h0, exp_vec});
         if (!rd && idx >= 0) chk("write_bits", obs_bits(idx), exp_bits);
         @(posedge clock);
         #1;
         @(negedge clock);
         chk("strobe_T2", {22'h0, obs_vec()}, 32'h0);
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: observed still running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int nacc;
      int k;
      int exp_acc;
      core_val[0] = 32'h0000_3004;
      core_val[1] = 32'h1111_2222;
      core_val[2] = 32'h3333_4444;
      core_val[3] = 32'h0000_007F;
      core_val[4] = 32'h0000_0010;
      core_val[5] = 32'h0000_0020;
      core_val[6] = 32'h0000_0030;
      core_val[7] = 32'h0000_00C3;
      core_val[8] = 32'h0000_0000;
      core_val[9] = 32'hDEAD_BEEF;
      reset = 1'b1;
      icb.i_icb_cmd_valid = 1'b0;
      icb.i_icb_cmd_addr  = '0;
      icb.i_icb_cmd_read  = 1'b0;
      icb.i_icb_cmd_wdata = '0;
      icb.i_icb_cmd_wmask = '0;
      icb.i_icb_rsp_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("rst_cmd_ready", {31'h0, icb.o_icb_cmd_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, icb.o_icb_rsp_valid}, 32'h0);
      chk("rst_rsp_err",   {31'h0, icb.o_icb_rsp_err},   32'h0);
      chk("rst_rsp_rdata", icb.o_icb_rsp_rdata, 32'h0);
      chk("rst_strobes",   {22'h0, obs_vec()}, 32'h0);
      chk("rst_cfg_bits",  cfg_wb, 32'h0);
      @(posedge clock);
      #1;

      issue(12'h02C, 1'b0, 32'h0000_00A5, 4'hF);   // cmp_3 full write
      issue(12'h000, 1'b0, 32'h1200_0000, 4'h8);   // cfg partial -> 0x1200_3004
      issue(12'h010, 1'b1, 32'h0,         4'h0);   // s read, zero extended
      issue(12'h014, 1'b1, 32'h0,         4'h0);   // unmapped read
      issue(12'h030, 1'b0, 32'hFFFF_FFFF, 4'hF);   // unmapped write
      issue(12'h00A, 1'b0, 32'hFFFF_ABCD, 4'h3);   // countLo, low addr bits ignored
      issue(12'h01C, 1'b0, 32'h1234_5678, 4'h0);   // key, empty mask keeps value
      issue(12'h00C, 1'b1, 32'h0,         4'h0);   // countHi read
      issue(12'h100, 1'b1, 32'h0,         4'h0);   // high addr bits ignored -> cfg
      issue(12'h024, 1'b0, 32'h0000_5A00, 4'h2);   // cmp_1 upper byte only -> 0x20

      // back-to-back writes to feed
      icb.i_icb_cmd_valid = 1'b1;
      icb.i_icb_cmd_addr  = 12'h018;
      icb.i_icb_cmd_read  = 1'b0;
      icb.i_icb_cmd_wmask = 4'hF;
      icb.i_icb_cmd_wdata = 32'hCAFE_0001;
      exp_q.push_back('{rdata: 32'h0, err: 1'b0});
      @(negedge clock);
      chk("b2b_ready0", {31'h0, icb.o_icb_cmd_ready}, 32'h1);
      @(posedge clock);
      #1;
      icb.i_icb_cmd_wdata = 32'hCAFE_0002;
      exp_q.push_back('{rdata: 32'h0, err: 1'b0});
      @(negedge clock);
      chk("b2b_ready1", {31'h0, icb.o_icb_cmd_ready}, 32'h1);
      chk("b2b_strobe0", {22'h0, obs_vec()}, 32'h100);
      chk("b2b_bits0", feed_wb, 32'hCAFE_0001);
      @(posedge clock);
      #1;
      icb.i_icb_cmd_valid = 1'b0;
      @(negedge clock);
      chk("b2b_strobe1", {22'h0, obs_vec()}, 32'h100);
      chk("b2b_bits1", feed_wb, 32'hCAFE_0002);
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("b2b_strobe2", {22'h0, obs_vec()}, 32'h0);
      chk("b2b_bits_hold", feed_wb, 32'hCAFE_0002);
      @(posedge clock);
      #1;

      // backpressure: three reads offered while rsp_ready is low
`ifdef PWM8_REGIF_RSP_FIFO_EN
      exp_acc = 2;
`else
      exp_acc = 1;
`endif
      icb.i_icb_rsp_ready = 1'b0;
      nacc = 0;
      k    = 0;
      for (int c = 0; c < 5; c++) begin
         icb.i_icb_cmd_valid = (k < 3);
         icb.i_icb_cmd_addr  = 12'h020 + 12'(4 * k);
         icb.i_icb_cmd_read  = 1'b1;
         @(negedge clock);
         if (icb.i_icb_cmd_valid && icb.o_icb_cmd_ready) begin
            exp_q.push_back(exp_rsp(icb.i_icb_cmd_addr, 1'b1));
            nacc++;
            k++;
         end
         @(posedge clock);
         #1;
      end
      chk("bp_accepted", 32'(nacc), 32'(exp_acc));
      @(negedge clock);
      chk("bp_ready_low", {31'h0, icb.o_icb_cmd_ready}, 32'h0);
      icb.i_icb_cmd_valid = 1'b0;
      @(posedge clock);
      #1;
      icb.i_icb_rsp_ready = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      @(negedge clock);
      chk("bp_drained", 32'(exp_q.size()), 32'h0);
      chk("bp_ready_back", {31'h0, icb.o_icb_cmd_ready}, 32'h1);
      chk("bp_valid_low", {31'h0, icb.o_icb_rsp_valid}, 32'h0);
      @(posedge clock);
      #1;

      // reset while a response is pending
      icb.i_icb_rsp_ready = 1'b0;
      icb.i_icb_cmd_valid = 1'b1;
      icb.i_icb_cmd_addr  = 12'h000;
      icb.i_icb_cmd_read  = 1'b0;
      icb.i_icb_cmd_wdata = 32'h0000_00FF;
      icb.i_icb_cmd_wmask = 4'h1;
      @(posedge clock);
      #1;
      icb.i_icb_cmd_valid = 1'b0;
      exp_q.push_back('{rdata: 32'h0, err: 1'b0});
      chk("mid_rsp_pending", {31'h0, icb.o_icb_rsp_valid}, 32'h1);
      reset = 1'b1;
      #1;
      exp_q.delete();
      chk("mid_rst_valid", {31'h0, icb.o_icb_rsp_valid}, 32'h0);
      chk("mid_rst_strobe", {22'h0, obs_vec()}, 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      icb.i_icb_rsp_ready = 1'b1;
      repeat (2) begin
         @(negedge clock);
         chk("post_rst_strobe", {22'h0, obs_vec()}, 32'h0);
         chk("post_rst_valid", {31'h0, icb.o_icb_rsp_valid}, 32'h0);
      end
      @(posedge clock);
      #1;
      issue(12'h028, 1'b1, 32'h0, 4'h0);           // cmp_2 read after reset
      @(negedge clock);
      chk("final_queue_empty", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
